// File: rtl/int_arbiter.sv
// int_arbiter: prioritised interrupt arbiter for the single-cycle CPU.
// Latches rising edges on four request lines, filters them through a
// software mask and a global enable, picks one by fixed or round-robin
// priority and hands the control unit a one-cycle pulse plus ISR vector.
// No new grant is made until the control unit reports end of service,
// so ISRs never nest.
module int_arbiter #(
   parameter logic [9:0] VEC_BASE   = 10'h3C0,
   parameter logic [9:0] VEC_STRIDE = 10'd16,
   parameter bit         RR         = 1'b0,
   parameter logic [3:0] MASK_RST   = 4'b1111
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       intPort1,
   input  logic       intPort2,
   input  logic       intPort3,
   input  logic       intPort4,
   input  logic       ie,
   input  logic       we_mask,
   input  logic [3:0] mask_in,
   input  logic       clr_lost,
   input  logic       finInterrup,
   output logic       interruptionToUC,
   output logic [9:0] vector,
   output logic [1:0] active_id,
   output logic       in_service,
   output logic [3:0] pending,
   output logic [3:0] mask,
   output logic [3:0] lost
);

   // Encoding chosen so each output is a single state bit:
   // bit 1 = in service, bit 0 = take-interrupt pulse.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_ISSUE   = 2'b11,
      ST_SERVICE = 2'b10
   } state_t;

   state_t     r_state;
   state_t     w_state_next;

   logic [3:0] w_lines;
   logic [3:0] r_prev;
   logic [3:0] r_pending;
   logic [3:0] r_mask;
   logic [3:0] r_lost;
   logic [3:0] w_edge;
   logic [3:0] w_cand;
   logic [3:0] w_clear;
   logic [1:0] r_last;
   logic [1:0] r_active_id;
   logic [1:0] w_base;
   logic [1:0] w_winner;
   logic       w_found;
   logic       w_grant;
   logic [9:0] r_vector;
   logic [9:0] w_vector;

   assign w_lines = {intPort4, intPort3, intPort2, intPort1};
   assign w_edge  = w_lines & ~r_prev;
   assign w_cand  = r_pending & r_mask;
   assign w_grant = (r_state == ST_IDLE) && ie && (w_cand != 4'b0000);

   // Round-robin starts the search just after the previous winner;
   // fixed priority always starts at port1.
   assign w_base  = RR ? (r_last + 2'd1) : 2'd0;

   // Pick the first candidate walking upward (with wrap) from w_base.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path
      // through the block leaves it unassigned and no latch is inferred.
      w_winner = 2'd0;
      w_found  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (!w_found && w_cand[w_base + 2'(i)]) begin
            w_winner = w_base + 2'(i);
            w_found  = 1'b1;
         end
      end
   end

   assign w_clear  = w_grant ? (4'b0001 << w_winner) : 4'b0000;
   assign w_vector = VEC_BASE + 10'(w_winner) * VEC_STRIDE;

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: reset is sampled on the clock edge like any other input,
      // so it sits inside the clocked branch rather than in the sensitivity list.
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic: grant from IDLE, one ISSUE cycle, hold until return.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:    if (w_grant) w_state_next = ST_ISSUE;
         ST_ISSUE:   w_state_next = ST_SERVICE;
         ST_SERVICE: if (finInterrup) w_state_next = ST_IDLE;
         default:    w_state_next = ST_IDLE;
      endcase
   end

   // Outputs decoded straight from state bits; no input reaches them.
   always_comb begin
      interruptionToUC = r_state[0];
      in_service       = r_state[1];
   end

   // Request bookkeeping, mask, and the vector/id latched at grant time.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register sees the pre-edge values of the others.
      if (reset) begin
         r_prev      <= 4'b0000;
         r_pending   <= 4'b0000;
         r_lost      <= 4'b0000;
         r_mask      <= MASK_RST;
         r_last      <= 2'd3;
         r_active_id <= 2'd0;
         r_vector    <= 10'd0;
      end else begin
         r_prev    <= w_lines;
         // A fresh edge on the winner's line re-arms it in the same cycle.
         r_pending <= (r_pending & ~w_clear) | w_edge;
         r_lost    <= (clr_lost ? 4'b0000 : r_lost) | (w_edge & r_pending);
         if (we_mask) begin
            r_mask <= mask_in;
         end
         if (w_grant) begin
            r_last      <= w_winner;
            r_active_id <= w_winner;
            r_vector    <= w_vector;
         end
      end
   end

   assign vector    = r_vector;
   assign active_id = r_active_id;
   assign pending   = r_pending;
   assign mask      = r_mask;
   assign lost      = r_lost;

endmodule

// File: tb/tb_int_arbiter.sv
// Bench for int_arbiter: one fixed-priority and one round-robin instance
// share the same stimulus and are compared each cycle against a
// behavioural model, plus directed scenarios with constant expectations.
module tb_int_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] lines;
   logic       ie;
   logic       we_mask;
   logic [3:0] mask_in;
   logic       clr_lost;
   logic       fin;

   logic       o_pulse [2];
   logic [9:0] o_vec   [2];
   logic [1:0] o_id    [2];
   logic       o_svc   [2];
   logic [3:0] o_pend  [2];
   logic [3:0] o_mask  [2];
   logic [3:0] o_lost  [2];

   always #5 clk = ~clk;

   int_arbiter #(.RR(1'b0)) dut0 (
      .clk(clk), .reset(reset),
      .intPort1(lines[0]), .intPort2(lines[1]), .intPort3(lines[2]), .intPort4(lines[3]),
      .ie(ie), .we_mask(we_mask), .mask_in(mask_in), .clr_lost(clr_lost), .finInterrup(fin),
      .interruptionToUC(o_pulse[0]), .vector(o_vec[0]), .active_id(o_id[0]),
      .in_service(o_svc[0]), .pending(o_pend[0]), .mask(o_mask[0]), .lost(o_lost[0])
   );

   int_arbiter #(.RR(1'b1)) dut1 (
      .clk(clk), .reset(reset),
      .intPort1(lines[0]), .intPort2(lines[1]), .intPort3(lines[2]), .intPort4(lines[3]),
      .ie(ie), .we_mask(we_mask), .mask_in(mask_in), .clr_lost(clr_lost), .finInterrup(fin),
      .interruptionToUC(o_pulse[1]), .vector(o_vec[1]), .active_id(o_id[1]),
      .in_service(o_svc[1]), .pending(o_pend[1]), .mask(o_mask[1]), .lost(o_lost[1])
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // Behavioural model: phase 0 = waiting, 1 = pulse cycle, 2 = in ISR.
   int       m_phase [2];
   bit [3:0] m_prev  [2];
   bit [3:0] m_pend  [2];
   bit [3:0] m_lost  [2];
   bit [3:0] m_mask  [2];
   int       m_last  [2];
   int       m_id    [2];
   int       m_vec   [2];

   function automatic int vec_of(input int n);
      return (960 + n * 16) % 1024;
   endfunction

   task automatic model_step(input int k, input bit rr);
      bit [3:0] edges;
      bit [3:0] pend_n;
      bit [3:0] lost_n;
      int       win;
      if (reset) begin
         m_phase[k] = 0; m_prev[k] = 0; m_pend[k] = 0; m_lost[k] = 0;
         m_mask[k] = 4'hF; m_last[k] = 3; m_id[k] = 0; m_vec[k] = 0;
         return;
      end
      win = -1;
      for (int n = 0; n < 4; n++) edges[n] = lines[n] && !m_prev[k][n];
      if (m_phase[k] == 0 && ie) begin
         for (int j = 0; j < 4; j++) begin
            int n = rr ? (m_last[k] + 1 + j) % 4 : j;
            if (win < 0 && m_pend[k][n] && m_mask[k][n]) win = n;
         end
      end
      for (int n = 0; n < 4; n++) begin
         pend_n[n] = edges[n] ? 1'b1 : ((n == win) ? 1'b0 : m_pend[k][n]);
         lost_n[n] = (!clr_lost && m_lost[k][n]) || (edges[n] && m_pend[k][n]);
      end
      case (m_phase[k])
         0: if (win >= 0) begin
               m_phase[k] = 1; m_id[k] = win; m_vec[k] = vec_of(win); m_last[k] = win;
            end
         1: m_phase[k] = 2;
         default: if (fin) m_phase[k] = 0;
      endcase
      m_pend[k] = pend_n;
      m_lost[k] = lost_n;
      if (we_mask) m_mask[k] = mask_in;
      m_prev[k] = lines;
   endtask

   task automatic compare_all();
      for (int k = 0; k < 2; k++) begin
         check($sformatf("pulse%0d", k),   o_pulse[k], m_phase[k] == 1);
         check($sformatf("svc%0d", k),     o_svc[k],   m_phase[k] != 0);
         check($sformatf("vector%0d", k),  o_vec[k],   m_vec[k]);
         check($sformatf("id%0d", k),      o_id[k],    m_id[k]);
         check($sformatf("pending%0d", k), o_pend[k],  m_pend[k]);
         check($sformatf("mask%0d", k),    o_mask[k],  m_mask[k]);
         check($sformatf("lost%0d", k),    o_lost[k],  m_lost[k]);
      end
   endtask

   // Model advances on the pre-edge inputs; outputs sampled 1 ns after the edge.
   task automatic step();
      model_step(0, 1'b0);
      model_step(1, 1'b1);
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      reset = 1'b1; lines = 4'b0000; ie = 1'b0; we_mask = 1'b0;
      mask_in = 4'b0000; clr_lost = 1'b0; fin = 1'b0;
      step();
      reset = 1'b0;
   endtask

   task automatic wait_pulse(input int k, output int cyc);
      bit found = 1'b0;
      cyc = 0;
      while (!found && cyc < 40) begin
         step();
         cyc++;
         if (o_pulse[k] === 1'b1) found = 1'b1;
      end
      check("pulse_seen", found, 1'b1);
   endtask

   int       cyc;
   int       npulse;
   int       ngrant;
   bit [1:0] got_id [5];
   bit [1:0] exp_rr [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

   initial begin
      reset = 1'b1; lines = 4'b0100; ie = 1'b1; we_mask = 1'b0;
      mask_in = 4'b0000; clr_lost = 1'b0; fin = 1'b0;

      // Line already high at reset release: pulse in 2nd cycle, port3 vector.
      step();
      check("rst_pulse", o_pulse[0], 1'b0);
      check("rst_vector", o_vec[0], 10'h000);
      check("rst_mask", o_mask[0], 4'hF);
      reset = 1'b0;
      step();
      check("p3_pending", o_pend[0][2], 1'b1);
      check("p3_no_pulse_yet", o_pulse[0], 1'b0);
      step();
      check("p3_pulse", o_pulse[0], 1'b1);
      check("p3_vector", o_vec[0], 10'h3E0);
      check("p3_id", o_id[0], 2'd2);
      check("p3_pend_clear", o_pend[0][2], 1'b0);

      // Ports 1 and 4 together, fixed priority: port1 then port4 after one idle cycle.
      do_reset();
      ie = 1'b1; lines = 4'b1001;
      wait_pulse(0, cyc);
      check("fx_first_vec", o_vec[0], 10'h3C0);
      step();
      fin = 1'b1;
      step();
      fin = 1'b0;
      check("fx_idle_gap", o_svc[0], 1'b0);
      wait_pulse(0, cyc);
      check("fx_gap_cycles", cyc, 1);
      check("fx_second_vec", o_vec[0], 10'h3F0);
      check("fx_second_id", o_id[0], 2'd3);

      // Round-robin with all lines continuously re-pending.
      do_reset();
      ie = 1'b1; fin = 1'b1; ngrant = 0;
      for (int c = 0; c < 60 && ngrant < 5; c++) begin
         lines = c[0] ? 4'hF : 4'h0;
         step();
         if (o_pulse[1] === 1'b1) begin
            got_id[ngrant] = o_id[1];
            ngrant++;
         end
      end
      check("rr_grants", ngrant, 5);
      for (int g = 0; g < 5; g++) check($sformatf("rr_order%0d", g), got_id[g], exp_rr[g]);

      // Masked request stays pending; unmasking grants two cycles later.
      do_reset();
      ie = 1'b1; we_mask = 1'b1; mask_in = 4'b1110;
      step();
      we_mask = 1'b0; lines = 4'b0001;
      step(); step(); step();
      check("mk_no_pulse", o_pulse[0], 1'b0);
      check("mk_pending", o_pend[0][0], 1'b1);
      we_mask = 1'b1; mask_in = 4'b1111;
      step();
      we_mask = 1'b0;
      check("mk_old_mask_used", o_pulse[0], 1'b0);
      step();
      check("mk_pulse", o_pulse[0], 1'b1);
      check("mk_vector", o_vec[0], 10'h3C0);

      // Two port2 edges during port1 service: lost flag, single later service.
      do_reset();
      ie = 1'b1; lines = 4'b0001;
      wait_pulse(0, cyc);
      lines = 4'b0011; step();
      lines = 4'b0001; step();
      lines = 4'b0011; step();
      check("ls_lost_set", o_lost[0][1], 1'b1);
      fin = 1'b1; step(); fin = 1'b0;
      wait_pulse(0, cyc);
      check("ls_served_id", o_id[0], 2'd1);
      step();
      fin = 1'b1;
      npulse = 0;
      for (int c = 0; c < 6; c++) begin
         step();
         if (o_pulse[0] === 1'b1) npulse++;
      end
      fin = 1'b0;
      check("ls_served_once", npulse, 0);
      clr_lost = 1'b1; step(); clr_lost = 1'b0;
      check("ls_cleared", o_lost[0], 4'b0000);

      // Reset in service with finInterrup: everything back to reset values.
      do_reset();
      ie = 1'b1; lines = 4'b0001;
      wait_pulse(0, cyc);
      step();
      check("rs_in_service", o_svc[0], 1'b1);
      reset = 1'b1; fin = 1'b1;
      step();
      check("rs_svc", o_svc[0], 1'b0);
      check("rs_vector", o_vec[0], 10'h000);
      check("rs_id", o_id[0], 2'd0);
      check("rs_pend", o_pend[0], 4'b0000);
      reset = 1'b0; fin = 1'b0; lines = 4'b0000;
      npulse = 0;
      for (int c = 0; c < 4; c++) begin
         step();
         if (o_pulse[0] === 1'b1) npulse++;
      end
      check("rs_no_pulse", npulse, 0);

      // Randomized traffic against the model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         reset    = ($urandom_range(0, 499) == 0);
         lines    = lines ^ (4'($urandom) & 4'($urandom));
         ie       = ($urandom_range(0, 7) != 0);
         we_mask  = ($urandom_range(0, 15) == 0);
         mask_in  = 4'($urandom);
         clr_lost = ($urandom_range(0, 15) == 0);
         fin      = ($urandom_range(0, 3) == 0);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
